// File: rtl/axis_bram_adapter_pkg.sv
// rtl/axis_bram_adapter_pkg.sv - shared state encoding and helpers for the AXIS/BRAM line mover
package axis_bram_adapter_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_FILL   = 3'd1,
    S_WR_COMMIT = 3'd2,
    S_RD_ISSUE  = 3'd3,
    S_RD_WAIT   = 3'd4,
    S_RD_DRAIN  = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  localparam int MAX_WORD_W = 256;
  localparam logic [MAX_WORD_W-1:0] ZERO_WORD = '0;

  function automatic int wcnt_w(input int words);
    return (words < 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/axis_bram_adapter_v2_0_linebuf.sv
// rtl/axis_bram_adapter_v2_0_linebuf.sv - one BRAM line of words: per-word write, whole-line load, clear, word read mux
module axis_bram_adapter_v2_0_linebuf
  import axis_bram_adapter_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int WORDS      = 36,
  parameter int WCNT_W     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        wr_en_i,
  input  logic [WCNT_W-1:0]           wr_idx_i,
  input  logic [WORD_WIDTH-1:0]       wr_data_i,
  input  logic                        load_i,
  input  logic [WORD_WIDTH*WORDS-1:0] load_data_i,
  input  logic [WCNT_W-1:0]           rd_idx_i,
  output logic [WORD_WIDTH-1:0]       rd_data_o,
  output logic [WORD_WIDTH*WORDS-1:0] line_o
);

  logic [WORD_WIDTH-1:0] word_q [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORDS; i++) begin
      if (rst || clr_i) begin
        word_q[i] <= ZERO_WORD[WORD_WIDTH-1:0];
      end else if (load_i) begin
        word_q[i] <= load_data_i[i*WORD_WIDTH +: WORD_WIDTH];
      end else if (wr_en_i && (int'(wr_idx_i) == i)) begin
        word_q[i] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = word_q[rd_idx_i];

  for (genvar g = 0; g < WORDS; g++) begin : g_line
    assign line_o[g*WORD_WIDTH +: WORD_WIDTH] = word_q[g];
  end

endmodule

// File: rtl/axis_bram_adapter_v2_0_engine.sv
// rtl/axis_bram_adapter_v2_0_engine.sv - packs/unpacks AXIS words to/from BRAM lines; start/done commanded
// AXIS_BRAM_ADAPTER_PARTIAL_FLUSH_EN: early s_axis_tlast commits a zero-padded line and ends the transfer
module axis_bram_adapter_v2_0_engine
  import axis_bram_adapter_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 36,
  parameter int ADDR_WIDTH     = 9
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 rw,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [ADDR_WIDTH:0]                  line_count,
  output logic                                 busy,
  output logic                                 done,
  input  logic [WORD_WIDTH-1:0]                s_axis_tdata,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  output logic [WORD_WIDTH-1:0]                m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic                                 bram_en,
  output logic                                 bram_we,
  output logic [ADDR_WIDTH-1:0]                bram_addr,
  output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] bram_wdata,
  input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] bram_rdata
);

  localparam int WCNT_W = wcnt_w(WORDS_PER_LINE);
  localparam logic [WCNT_W-1:0]     WCNT_LAST = WCNT_W'(WORDS_PER_LINE - 1);
  localparam logic [WCNT_W-1:0]     WCNT_ONE  = WCNT_W'(1);
  localparam logic [ADDR_WIDTH:0]   LCNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q, addr_q;
  logic [ADDR_WIDTH:0]     line_count_q, lcnt_q, lcnt_d;
  logic [WCNT_W-1:0]       wcnt_q;
  logic                    busy_q, done_q, s_tready_q, m_tvalid_q, en_q, we_q, flush_q;
  logic                    hs_in, hs_out, last_line, early_last;
  logic                    lb_wr, lb_load, lb_clr;
  logic [ADDR_WIDTH-1:0]   cur_addr;

  assign hs_in     = s_tready_q && s_axis_tvalid;
  assign hs_out    = m_tvalid_q && m_axis_tready;
  assign lcnt_d    = lcnt_q + LCNT_ONE;
  assign last_line = (lcnt_d == line_count_q);
  assign cur_addr  = base_q + lcnt_q[ADDR_WIDTH-1:0];

`ifdef AXIS_BRAM_ADAPTER_PARTIAL_FLUSH_EN
  assign early_last = s_axis_tlast && (wcnt_q != WCNT_LAST);
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign early_last   = 1'b0;
`endif

  // Buffer is cleared at the start of every fill so a short flushed line pads with zeros.
  assign lb_wr   = (state_q == S_WR_FILL) && hs_in;
  assign lb_load = (state_q == S_RD_WAIT);
  assign lb_clr  = ((state_q == S_IDLE) && start) || (state_q == S_WR_COMMIT);

  axis_bram_adapter_v2_0_linebuf #(
    .WORD_WIDTH (WORD_WIDTH),
    .WORDS      (WORDS_PER_LINE),
    .WCNT_W     (WCNT_W)
  ) u_linebuf (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (lb_clr),
    .wr_en_i     (lb_wr),
    .wr_idx_i    (wcnt_q),
    .wr_data_i   (s_axis_tdata),
    .load_i      (lb_load),
    .load_data_i (bram_rdata),
    .rd_idx_i    (wcnt_q),
    .rd_data_o   (m_axis_tdata),
    .line_o      (bram_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      addr_q       <= '0;
      line_count_q <= '0;
      lcnt_q       <= '0;
      wcnt_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      s_tready_q   <= 1'b0;
      m_tvalid_q   <= 1'b0;
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (line_count == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              base_q       <= base_addr;
              line_count_q <= line_count;
              lcnt_q       <= '0;
              wcnt_q       <= '0;
              flush_q      <= 1'b0;
              busy_q       <= 1'b1;
              if (rw) begin
                state_q    <= S_WR_FILL;
                s_tready_q <= 1'b1;
              end else begin
                state_q <= S_RD_ISSUE;
                en_q    <= 1'b1;
                addr_q  <= base_addr;
              end
            end
          end
        end
        S_WR_FILL: begin
          if (hs_in) begin
            wcnt_q <= wcnt_q + WCNT_ONE;
            if ((wcnt_q == WCNT_LAST) || early_last) begin
              state_q    <= S_WR_COMMIT;
              s_tready_q <= 1'b0;
              en_q       <= 1'b1;
              we_q       <= 1'b1;
              addr_q     <= cur_addr;
              flush_q    <= early_last;
            end
          end
        end
        S_WR_COMMIT: begin
          lcnt_q <= lcnt_d;
          wcnt_q <= '0;
          if (last_line || flush_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q    <= S_WR_FILL;
            s_tready_q <= 1'b1;
          end
        end
        S_RD_ISSUE: state_q <= S_RD_WAIT;
        S_RD_WAIT: begin
          state_q    <= S_RD_DRAIN;
          m_tvalid_q <= 1'b1;
          wcnt_q     <= '0;
        end
        S_RD_DRAIN: begin
          if (hs_out) begin
            if (wcnt_q == WCNT_LAST) begin
              m_tvalid_q <= 1'b0;
              lcnt_q     <= lcnt_d;
              wcnt_q     <= '0;
              if (last_line) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_RD_ISSUE;
                en_q    <= 1'b1;
                addr_q  <= cur_addr + ADDR_ONE;
              end
            end else begin
              wcnt_q <= wcnt_q + WCNT_ONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign s_axis_tready = s_tready_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tvalid_q && (wcnt_q == WCNT_LAST) && last_line;
  assign bram_en       = en_q;
  assign bram_we       = we_q;
  assign bram_addr     = addr_q;

endmodule
